// File: rtl/uart_cmd_parser_pkg.sv
// Shared sequencer definitions: data-path sizing, ASCII constants and parser types.
// No logic here; imported by the UART command parser.
package uart_cmd_parser_pkg;

  localparam int SEQ_DP_WIDTH = 16;
  localparam int UART_NUM_NIB = SEQ_DP_WIDTH / 4;

  localparam logic [7:0] ASCII_W     = 8'h57;
  localparam logic [7:0] ASCII_R     = 8'h52;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_3     = 8'h33;
  localparam logic [7:0] ASCII_9     = 8'h39;
  localparam logic [7:0] ASCII_UC_A  = 8'h41;
  localparam logic [7:0] ASCII_UC_F  = 8'h46;
  localparam logic [7:0] ASCII_LC_A  = 8'h61;
  localparam logic [7:0] ASCII_LC_F  = 8'h66;

  typedef enum logic [2:0] {
    stIdle,
    stWReg,
    stWColon,
    stWData,
    stRReg,
    stRTerm,
    stRdWait,
    stErr
  } state_t;

  typedef struct packed {
    logic       vld;
    logic [3:0] nib;
  } hex_t;

endpackage

// File: rtl/uart_cmd_parser.sv
// ASCII "Wr:hhhh" / "Rr" line parser; strobes are registered, one cycle after the terminator.
// No backpressure: every i_rx_valid byte is consumed; a read waits only on i_tx_busy.
module uart_cmd_parser
  import uart_cmd_parser_pkg::*;
#(
  parameter int seq_dp_width = SEQ_DP_WIDTH,
  parameter int uart_num_nib = seq_dp_width / 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [7:0]              i_rx_data,
  input  logic                    i_rx_valid,
  input  logic                    i_tx_busy,
  output logic                    o_wr_stb,
  output logic [1:0]              o_wr_reg,
  output logic [seq_dp_width-1:0] o_wr_data,
  output logic                    o_rd_stb,
  output logic [1:0]              o_rd_reg,
  output logic                    o_err_stb
);

  localparam int CNT_W = $clog2(uart_num_nib + 1);
  localparam logic [CNT_W-1:0] NIB_FULL = CNT_W'(uart_num_nib);

  function automatic hex_t hex_decode(input logic [7:0] c);
    hex_t h;
    h.vld = 1'b1;
    h.nib = c[3:0];
    if ((c >= ASCII_0) && (c <= ASCII_9)) begin
      h.nib = c[3:0];
    end else if (((c >= ASCII_UC_A) && (c <= ASCII_UC_F)) ||
                 ((c >= ASCII_LC_A) && (c <= ASCII_LC_F))) begin
      h.nib = c[3:0] + 4'd9;
    end else begin
      h.vld = 1'b0;
    end
    return h;
  endfunction

  state_t                  r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic [seq_dp_width-1:0] r_shift;
  logic [1:0]              r_reg;

  hex_t w_hex;
  logic w_term;
  logic w_reg_ok;

  always_comb begin
    w_hex    = hex_decode(i_rx_data);
    w_term   = (i_rx_data == ASCII_CR) || (i_rx_data == ASCII_LF);
    w_reg_ok = (i_rx_data >= ASCII_0) && (i_rx_data <= ASCII_3);
  end

  // A terminator that breaks a command reports at once; waiting in stErr
  // for another terminator would swallow the following line.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= stIdle;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_reg     <= 2'd0;
      o_wr_stb  <= 1'b0;
      o_wr_reg  <= 2'd0;
      o_wr_data <= '0;
      o_rd_stb  <= 1'b0;
      o_rd_reg  <= 2'd0;
      o_err_stb <= 1'b0;
    end else begin
      o_wr_stb  <= 1'b0;
      o_rd_stb  <= 1'b0;
      o_err_stb <= 1'b0;
      case (r_state)
        stIdle: begin
          if (i_rx_valid) begin
            if (i_rx_data == ASCII_W) begin
              r_state <= stWReg;
            end else if (i_rx_data == ASCII_R) begin
              r_state <= stRReg;
            end else if (!w_term) begin
              r_state <= stErr;
            end
          end
        end
        stWReg: begin
          if (i_rx_valid) begin
            if (w_reg_ok) begin
              r_reg   <= i_rx_data[1:0];
              r_state <= stWColon;
            end else if (w_term) begin
              o_err_stb <= 1'b1;
              r_state   <= stIdle;
            end else begin
              r_state <= stErr;
            end
          end
        end
        stWColon: begin
          if (i_rx_valid) begin
            if (i_rx_data == ASCII_COLON) begin
              r_cnt   <= '0;
              r_shift <= '0;
              r_state <= stWData;
            end else if (w_term) begin
              o_err_stb <= 1'b1;
              r_state   <= stIdle;
            end else begin
              r_state <= stErr;
            end
          end
        end
        stWData: begin
          if (i_rx_valid) begin
            if (w_hex.vld) begin
              if (r_cnt == NIB_FULL) begin
                r_state <= stErr;
              end else begin
                r_shift <= {r_shift[seq_dp_width-5:0], w_hex.nib};
                r_cnt   <= r_cnt + 1'b1;
              end
            end else if (w_term) begin
              if (r_cnt == NIB_FULL) begin
                o_wr_stb  <= 1'b1;
                o_wr_reg  <= r_reg;
                o_wr_data <= r_shift;
              end else begin
                o_err_stb <= 1'b1;
              end
              r_state <= stIdle;
            end else begin
              r_state <= stErr;
            end
          end
        end
        stRReg: begin
          if (i_rx_valid) begin
            if (w_reg_ok) begin
              r_reg   <= i_rx_data[1:0];
              r_state <= stRTerm;
            end else if (w_term) begin
              o_err_stb <= 1'b1;
              r_state   <= stIdle;
            end else begin
              r_state <= stErr;
            end
          end
        end
        stRTerm: begin
          if (i_rx_valid) begin
            if (w_term) begin
              if (i_tx_busy) begin
                r_state <= stRdWait;
              end else begin
                o_rd_stb <= 1'b1;
                o_rd_reg <= r_reg;
                r_state  <= stIdle;
              end
            end else begin
              r_state <= stErr;
            end
          end
        end
        stRdWait: begin
          // Bytes arriving here are lost; the read itself stays pending.
          if (i_rx_valid) begin
            o_err_stb <= 1'b1;
          end
          if (!i_tx_busy) begin
            o_rd_stb <= 1'b1;
            o_rd_reg <= r_reg;
            r_state  <= stIdle;
          end
        end
        stErr: begin
          if (i_rx_valid && w_term) begin
            o_err_stb <= 1'b1;
            r_state   <= stIdle;
          end
        end
        default: r_state <= stIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Scoreboard bench for uart_cmd_parser: stimulus pushes expected strobes, a negedge monitor pops and compares.
module tb_uart_cmd_parser;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  i_rx_data = 8'h00;
  logic        i_rx_valid = 1'b0;
  logic        i_tx_busy = 1'b0;
  logic        o_wr_stb;
  logic [1:0]  o_wr_reg;
  logic [15:0] o_wr_data;
  logic        o_rd_stb;
  logic [1:0]  o_rd_reg;
  logic        o_err_stb;

  uart_cmd_parser #(.seq_dp_width(16), .uart_num_nib(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .i_rx_data (i_rx_data),
    .i_rx_valid(i_rx_valid),
    .i_tx_busy (i_tx_busy),
    .o_wr_stb  (o_wr_stb),
    .o_wr_reg  (o_wr_reg),
    .o_wr_data (o_wr_data),
    .o_rd_stb  (o_rd_stb),
    .o_rd_reg  (o_rd_reg),
    .o_err_stb (o_err_stb)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [1:0]  rg;
    logic [15:0] data;
  } exp_t;

  exp_t q_wr[$];
  exp_t q_rd[$];
  int   q_err[$];
  exp_t e_m;
  int   c_m;

  int n_checks = 0;
  int n_pass   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
  endfunction

  function automatic void unexp(input string name);
    n_checks++;
    $display("FAIL %s: strobe at cycle %0d with nothing expected", name, cyc);
  endfunction

  task automatic push_wr(input int c, input logic [1:0] r, input logic [15:0] d);
    exp_t e;
    e.cyc = c; e.rg = r; e.data = d;
    q_wr.push_back(e);
  endtask

  task automatic push_rd(input int c, input logic [1:0] r);
    exp_t e;
    e.cyc = c; e.rg = r; e.data = 16'h0;
    q_rd.push_back(e);
  endtask

  // t = cycle in which the byte was sampled; a strobe it causes is seen in that cycle's low phase.
  task automatic send_byte(input logic [7:0] b, output int t);
    @(posedge clk); #1;
    i_rx_data  = b;
    i_rx_valid = 1'b1;
    @(posedge clk); #1;
    i_rx_valid = 1'b0;
    t = cyc;
  endtask

  task automatic send_str(input string s, output int t);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], t);
  endtask

  always @(negedge clk) begin
    if (o_wr_stb) begin
      if (q_wr.size() == 0) unexp("unexpected_wr_stb");
      else begin
        e_m = q_wr.pop_front();
        chk("wr_cycle", 32'(cyc), 32'(e_m.cyc));
        chk("wr_reg", 32'(o_wr_reg), 32'(e_m.rg));
        chk("wr_data", 32'(o_wr_data), 32'(e_m.data));
      end
    end
    if (o_rd_stb) begin
      if (q_rd.size() == 0) unexp("unexpected_rd_stb");
      else begin
        e_m = q_rd.pop_front();
        chk("rd_cycle", 32'(cyc), 32'(e_m.cyc));
        chk("rd_reg", 32'(o_rd_reg), 32'(e_m.rg));
      end
    end
    if (o_err_stb) begin
      if (q_err.size() == 0) unexp("unexpected_err_stb");
      else begin
        c_m = q_err.pop_front();
        chk("err_cycle", 32'(cyc), 32'(c_m));
      end
    end
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_stb", 32'(o_wr_stb), 32'd0);
    chk("rst_rd_stb", 32'(o_rd_stb), 32'd0);
    chk("rst_err_stb", 32'(o_err_stb), 32'd0);
    chk("rst_wr_reg", 32'(o_wr_reg), 32'd0);
    chk("rst_wr_data", 32'(o_wr_data), 32'd0);
    chk("rst_rd_reg", 32'(o_rd_reg), 32'd0);
    rst = 1'b0;

    send_str("W2:BEEF\r", t); push_wr(t, 2'd2, 16'hBEEF);
    send_str("W1:00a5\r", t); push_wr(t, 2'd1, 16'h00A5);
    send_str("\n", t);
    repeat (3) @(posedge clk);

    // Read held off by a busy transmitter; a stray byte meanwhile is reported.
    #1 i_tx_busy = 1'b1;
    send_str("R3\r", t);
    repeat (5) @(posedge clk);
    send_byte("Z", t); q_err.push_back(t);
    repeat (12) @(posedge clk);
    #1 i_tx_busy = 1'b0;
    push_rd(cyc + 1, 2'd3);
    repeat (3) @(posedge clk);

    send_str("R0\r", t); push_rd(t, 2'd0);
    send_str("W3:c0De\r", t); push_wr(t, 2'd3, 16'hC0DE);

    send_str("W0:12\r", t); q_err.push_back(t);
    send_str("W0:12345\r", t); q_err.push_back(t);
    send_str("X\r", t); q_err.push_back(t);

    send_str("W4:1234\r", t); q_err.push_back(t);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_wr_reg", 32'(o_wr_reg), 32'd3);
    chk("hold_wr_data", 32'(o_wr_data), 32'hC0DE);

    send_str("W3:AB", t);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_wr_reg", 32'(o_wr_reg), 32'd0);
    chk("midrst_wr_data", 32'(o_wr_data), 32'd0);
    chk("midrst_rd_reg", 32'(o_rd_reg), 32'd0);
    rst = 1'b0;
    send_str("CD\r", t); q_err.push_back(t);

    for (int i = 0; i < 50 && (q_wr.size() + q_rd.size() + q_err.size()) != 0; i++)
      @(posedge clk);
    repeat (10) @(posedge clk);
    #1;
    chk("pending_wr", 32'(q_wr.size()), 32'd0);
    chk("pending_rd", 32'(q_rd.size()), 32'd0);
    chk("pending_err", 32'(q_err.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL take parameter seq_dp_width, default 16: data path width in bits, taken from seq_definitions.v.
REQ-002 SHALL take parameter uart_num_nib, default seq_dp_width/4: number of hex digits in a write command, taken from seq_definitions.v.
REQ-003 SHALL have port clk  input  1  clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port i_rx_data  input  8  received byte from the UART receiver.
REQ-006 SHALL have port i_rx_valid  input  1  one-cycle strobe; i_rx_data is valid in that cycle.
REQ-007 SHALL have port i_tx_busy  input  1  high while the report transmitter is emitting a line.
REQ-008 SHALL have port o_wr_stb  output  1  one-cycle register-write strobe.
REQ-009 SHALL have port o_wr_reg  output  2  write register index; held until the next write.
REQ-010 SHALL have port o_wr_data  output  seq_dp_width  write data; held until the next write.
REQ-011 SHALL have port o_rd_stb  output  1  one-cycle read-request strobe to the report transmitter.
REQ-012 SHALL have port o_rd_reg  output  2  read register index; held until the next read.
REQ-013 SHALL have port o_err_stb  output  1  one-cycle strobe for a malformed or dropped command.

Function
REQ-014 SHALL accept the write command "W" reg ":" followed by exactly uart_num_nib hex digits and a terminator, where reg is "0".."3", the terminator is CR (0x0D) or LF (0x0A), and the first digit is the most significant nibble.
REQ-015 SHALL accept the read command "R" reg terminator.
REQ-016 SHALL accept "W" and "R" only in upper case, and SHALL accept hex digits 0-9, A-F and a-f.
REQ-017 SHALL use the states stIdle, stWReg, stWColon, stWData, stRReg, stRTerm, stRdWait and stErr.
REQ-018 SHALL advance at most one state per i_rx_valid byte, except for stRdWait, which exits on i_tx_busy alone.
REQ-019 In stIdle: "W" goes to stWReg; "R" goes to stRReg; CR or LF stays in stIdle with no error (empty line and CRLF pairs ignored); any other byte goes to stErr.
REQ-020 In stWData: SHALL shift each digit into a seq_dp_width shift register, left by 4, and count digits with a nibble counter.
REQ-021 A terminator received after exactly uart_num_nib digits SHALL pulse o_wr_stb in the next cycle, with o_wr_reg and o_wr_data updated in that same cycle, and return to stIdle.
REQ-022 A terminator received with fewer than uart_num_nib digits, or a digit received after uart_num_nib digits, SHALL go to stErr.
REQ-023 For a read terminator with i_tx_busy low, SHALL pulse o_rd_stb in the next cycle with o_rd_reg valid.
REQ-024 For a read terminator with i_tx_busy high, SHALL go to stRdWait and pulse o_rd_stb in the cycle after the first cycle in which i_tx_busy is low, then return to stIdle.
REQ-025 In stRdWait: any received byte SHALL be dropped and SHALL pulse o_err_stb one cycle later; the pending read is kept.
REQ-026 In stErr: SHALL discard bytes until a terminator, then pulse o_err_stb once, one cycle later, and return to stIdle.
REQ-027 An invalid byte in any parse state SHALL go to stErr.
REQ-028 o_wr_stb, o_rd_stb and o_err_stb SHALL never be high in the same cycle, except that an o_err_stb from REQ-025 may coincide with the o_rd_stb that ends stRdWait.
REQ-029 A byte arriving in the same cycle as an output strobe SHALL be processed normally; the block SHALL have no backpressure.

Reset
REQ-030 While rst is high: SHALL force state to stIdle, the nibble counter and shift register to 0, all strobes to 0, and o_wr_reg, o_wr_data and o_rd_reg to 0.
REQ-031 Reset in mid-command SHALL abandon the command without any strobe; parsing restarts at the next byte after rst deasserts.

Structure
REQ-032 seq_dp_width, uart_num_nib and the ASCII character constants SHALL reside in the shared seq_definitions.v.
REQ-033 ASCII-to-nibble decode SHALL be a local function that also returns a digit-valid flag; no sub-module is used.
REQ-034 All outputs SHALL be registered.

Verification (seq_dp_width=16)
REQ-035 Send "W2:BEEF\r" -> one o_wr_stb pulse, with o_wr_reg=2 and o_wr_data=0xBEEF, one cycle after the CR byte.
REQ-036 Send "W1:00a5\r\n" -> o_wr_data=0x00A5 with a single o_wr_stb, and no o_err_stb for the trailing LF.
REQ-037 Send "R3\r" with i_tx_busy held high for 20 cycles -> no o_rd_stb while busy, then exactly one o_rd_stb with o_rd_reg=3 one cycle after busy falls.
REQ-038 Send "W0:12\r", then "W0:12345\r", then "X\r" -> three o_err_stb pulses and no o_wr_stb.
REQ-039 Assert rst after "W3:AB", then send "CD\r" -> no o_wr_stb; "CD\r" is treated as an error (o_err_stb once).
REQ-040 Send "W4:1234\r" (register index out of range) -> o_err_stb, and o_wr_reg and o_wr_data keep their previous values.
